// File: rtl/ram_arb_pkg.sv
// Shared definitions for the SDRAM request arbiter: FSM encoding,
// client identifiers and default widths.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  // Client ids double as bit positions in the eligibility vector.
  localparam logic [1:0] CLI_CAM = 2'd0;
  localparam logic [1:0] CLI_HRD = 2'd1;
  localparam logic [1:0] CLI_HWR = 2'd2;

  localparam int ADDR_W_DEF = 25;
  localparam int DATA_W_DEF = 128;
  localparam int MAX_RD_DEF = 4;
  localparam int CNT_W      = 3;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select for the SDRAM arbiter.
// Camera always wins. With HDR_RR_ARB_EN defined, HDR read and HDR write
// alternate on a tie (the last-served one loses); otherwise read beats write.
module ram_arb_pick
  import ram_arb_pkg::*;
(
  input  logic [2:0] i_elig,
  input  logic       i_last_wr,
  output logic       o_any,
  output logic [1:0] o_win
);

  // Priority select over the eligible clients.
  always_comb begin
    o_any = |i_elig;
    o_win = CLI_CAM;
    if (i_elig[0]) begin
      o_win = CLI_CAM;
    end
`ifdef HDR_RR_ARB_EN
    else if (i_elig[1] && i_elig[2]) begin
      o_win = i_last_wr ? CLI_HRD : CLI_HWR;
    end
`endif
    else if (i_elig[1]) begin
      o_win = CLI_HRD;
    end else if (i_elig[2]) begin
      o_win = CLI_HWR;
    end
  end

`ifndef HDR_RR_ARB_EN
  // Fixed priority has no use for the last-served history.
  logic w_unused_last;
  assign w_unused_last = i_last_wr;
`endif

endmodule

// File: rtl/ram_arbiter.sv
// Responder side of the shared-SDRAM request interface.
// Arbitrates camera writes, HDR reads and HDR writes into single-beat
// controller commands, returns acks, read data and ram_busy.
// Optional HDR_RR_ARB_EN: round robin between HDR read and HDR write.
//
// Handshake: a command is transferred on any cycle where cmd_valid and
// cmd_ready are both 1; cmd_valid, cmd_write, cmd_addr and cmd_wdata are
// held stable from the rise of cmd_valid until that transfer.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int MAX_RD = MAX_RD_DEF
) (
  input  logic              clk_133M,
  input  logic              rst_n_133M,
  input  logic              camera_wr_req,
  input  logic [ADDR_W-1:0] camera_wr_addr,
  input  logic [DATA_W-1:0] camera_wr_data,
  output logic              camera_wr_ack,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_address,
  output logic              hdr_rd_ack,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_address,
  input  logic [DATA_W-1:0] wr_data,
  output logic              hdr_wr_ack,
  output logic              ram_busy,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output state_t            dbg_state
);

  localparam logic [CNT_W-1:0] MAX_RD_C = CNT_W'(MAX_RD);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_win;
  logic                r_cmd_write;
  logic [ADDR_W-1:0]   r_cmd_addr;
  logic [DATA_W-1:0]   r_cmd_wdata;
  logic [CNT_W-1:0]    r_out_cnt;
  logic                r_rsp_err;
  logic                r_rd_valid;
  logic [DATA_W-1:0]   r_rd_data;
  logic                r_last_wr;

  logic [2:0]          w_elig;
  logic                w_any;
  logic [1:0]          w_win;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic                w_grant;
  logic                w_rd_acc;
  logic                w_rsp_ok;

  // Arbitration only happens in IDLE, so a client is never re-picked in its
  // own ACK cycle; reads are held off while the controller has MAX_RD open.
  assign w_elig  = {wr_req, rd_req & (r_out_cnt != MAX_RD_C), camera_wr_req};
  assign w_grant = (r_state == ST_IDLE) && w_any;
  assign w_rd_acc = (r_state == ST_ISSUE) && cmd_ready && (r_win == CLI_HRD);
  assign w_rsp_ok = rsp_valid && (r_out_cnt != '0);

  ram_arb_pick u_pick (
    .i_elig    (w_elig),
    .i_last_wr (r_last_wr),
    .o_any     (w_any),
    .o_win     (w_win)
  );

  // Address/data mux for the client about to be granted.
  always_comb begin
    w_sel_addr  = camera_wr_addr;
    w_sel_wdata = camera_wr_data;
    case (w_win)
      CLI_HRD: begin
        w_sel_addr  = rd_address;
        w_sel_wdata = '0;
      end
      CLI_HWR: begin
        w_sel_addr  = wr_address;
        w_sel_wdata = wr_data;
      end
      default: begin
        w_sel_addr  = camera_wr_addr;
        w_sel_wdata = camera_wr_data;
      end
    endcase
  end

  // Next-state logic: IDLE -> ISSUE on a grant, ISSUE -> ACK on accept.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (cmd_ready) w_state_nxt = ST_ACK;
      ST_ACK:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk_133M or negedge rst_n_133M) begin
    if (!rst_n_133M) r_state <= ST_IDLE;
    else             r_state <= w_state_nxt;
  end

  // Capture the winning command on the grant; later input changes are ignored.
  always_ff @(posedge clk_133M or negedge rst_n_133M) begin
    if (!rst_n_133M) begin
      r_win       <= CLI_CAM;
      r_cmd_write <= 1'b0;
      r_cmd_addr  <= '0;
      r_cmd_wdata <= '0;
    end else if (w_grant) begin
      r_win       <= w_win;
      r_cmd_write <= (w_win != CLI_HRD);
      r_cmd_addr  <= w_sel_addr;
      r_cmd_wdata <= w_sel_wdata;
    end
  end

  // Remember which HDR client was served last (drives the round-robin tie).
  always_ff @(posedge clk_133M or negedge rst_n_133M) begin
    if (!rst_n_133M) begin
      r_last_wr <= 1'b0;
    end else if ((r_state == ST_ACK) && (r_win != CLI_CAM)) begin
      r_last_wr <= (r_win == CLI_HWR);
    end
  end

  // Outstanding read count and sticky error on unsolicited responses.
  always_ff @(posedge clk_133M or negedge rst_n_133M) begin
    if (!rst_n_133M) begin
      r_out_cnt <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      if (w_rd_acc && !w_rsp_ok)      r_out_cnt <= r_out_cnt + 1'b1;
      else if (!w_rd_acc && w_rsp_ok) r_out_cnt <= r_out_cnt - 1'b1;
      if (rsp_valid && (r_out_cnt == '0)) r_rsp_err <= 1'b1;
    end
  end

  // Registered read return path; unsolicited beats are dropped.
  always_ff @(posedge clk_133M or negedge rst_n_133M) begin
    if (!rst_n_133M) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rsp_ok;
      if (w_rsp_ok) r_rd_data <= rsp_data;
    end
  end

  assign cmd_valid     = (r_state == ST_ISSUE);
  assign cmd_write     = r_cmd_write;
  assign cmd_addr      = r_cmd_addr;
  assign cmd_wdata     = r_cmd_wdata;
  assign camera_wr_ack = (r_state == ST_ACK) && (r_win == CLI_CAM);
  assign hdr_rd_ack    = (r_state == ST_ACK) && (r_win == CLI_HRD);
  assign hdr_wr_ack    = (r_state == ST_ACK) && (r_win == CLI_HWR);
  assign ram_busy      = (r_state != ST_IDLE) | camera_wr_req;
  assign rd_valid      = r_rd_valid;
  assign rd_data       = r_rd_data;
  assign rsp_err       = r_rsp_err;
  assign dbg_state     = r_state;

endmodule
